// File: rtl/duty_value_display_pkg.sv
// Shared types and constants for the duty-cycle value display: converter FSM states,
// active-high seven-segment glyphs ({g,f,e,d,c,b,a}) and the nibble decoder.
package duty_value_display_pkg;

  localparam int DEF_VALUE_W = 17;
  localparam int DEF_DIGITS  = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } conv_state_e;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Codes 10-15 cannot come out of a correct conversion; show nothing rather than garbage.
  function automatic logic [6:0] nibble_to_glyph(input logic [3:0] nib);
    case (nib)
      4'd0:    return GLYPH_0;
      4'd1:    return GLYPH_1;
      4'd2:    return GLYPH_2;
      4'd3:    return GLYPH_3;
      4'd4:    return GLYPH_4;
      4'd5:    return GLYPH_5;
      4'd6:    return GLYPH_6;
      4'd7:    return GLYPH_7;
      4'd8:    return GLYPH_8;
      4'd9:    return GLYPH_9;
      default: return GLYPH_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/duty_value_display_if.sv
// Conversion handshake between the measurement stage and the display block:
// binary value and load request in, busy / packed BCD / valid pulse out.
interface duty_value_display_if #(
  parameter int VALUE_W = duty_value_display_pkg::DEF_VALUE_W,
  parameter int DIGITS  = duty_value_display_pkg::DEF_DIGITS
) ();

  logic [VALUE_W-1:0]  value;
  logic                load;
  logic                busy;
  logic [4*DIGITS-1:0] bcd;
  logic                bcd_valid;

  modport master (
    output value,
    output load,
    input  busy,
    input  bcd,
    input  bcd_valid
  );

  modport slave (
    input  value,
    input  load,
    output busy,
    output bcd,
    output bcd_valid
  );

endinterface

// File: rtl/duty_value_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, result latched into bcd
// on entry to DONE so the display never sees a half-built scratch value.
module bin2bcd_seq
  import duty_value_display_pkg::*;
#(
  parameter int VALUE_W = DEF_VALUE_W,
  parameter int DIGITS  = DEF_DIGITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [VALUE_W-1:0]  value,
  input  logic                load,
  output logic                busy,
  output logic [4*DIGITS-1:0] bcd,
  output logic                bcd_valid
);

  localparam int CNT_W = $clog2(VALUE_W + 1);

  conv_state_e         state_q, state_d;
  logic [VALUE_W-1:0]  shreg_q, shreg_d;
  logic [4*DIGITS-1:0] scratch_q, scratch_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] adjusted;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end

    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;

    // SHIFT spends one extra cycle at count zero to publish the finished scratch.
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          shreg_d   = value;
          scratch_d = '0;
          cnt_d     = CNT_W'(VALUE_W);
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          scratch_d = {adjusted[4*DIGITS-2:0], shreg_q[VALUE_W-1]};
          shreg_d   = {shreg_q[VALUE_W-2:0], 1'b0};
          cnt_d     = cnt_q - CNT_W'(1);
        end else begin
          bcd_d   = scratch_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q == ST_SHIFT);
  assign bcd_valid = (state_q == ST_DONE);
  assign bcd       = bcd_q;

endmodule

// File: rtl/duty_value_display.sv
// Duty-cycle value display: converts the measured value to BCD on request and scans it
// onto a multiplexed seven-segment display with leading-zero blanking.
module duty_value_display
  import duty_value_display_pkg::*;
#(
  parameter int VALUE_W        = DEF_VALUE_W,
  parameter int DIGITS         = DEF_DIGITS,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  duty_value_display_if.slave conv,
  input  logic                enable,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic                dp
);

  localparam int         REF_W   = $clog2(REFRESH_DIV);
  localparam int         IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

  logic [REF_W-1:0]  refresh_q, refresh_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        cur_nib;
  logic              lead_zero;
  logic [6:0]        glyph;

  bin2bcd_seq #(
    .VALUE_W (VALUE_W),
    .DIGITS  (DIGITS)
  ) u_conv (
    .clk       (clk),
    .reset     (reset),
    .value     (conv.value),
    .load      (conv.load),
    .busy      (conv.busy),
    .bcd       (conv.bcd),
    .bcd_valid (conv.bcd_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_q <= '0;
      idx_q     <= '0;
      an_q      <= '1;
      seg_q     <= SEG_OFF;
      dp_q      <= DP_OFF;
    end else begin
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  always_comb begin
    refresh_d = refresh_q + REF_W'(1);
    idx_d     = idx_q;
    if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      idx_d     = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    // A digit is a leading zero when it and every more significant digit are zero.
    cur_nib   = '0;
    lead_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == int'(idx_q)) cur_nib = conv.bcd[4*i +: 4];
      if ((i >= int'(idx_q)) && (conv.bcd[4*i +: 4] != 4'd0)) lead_zero = 1'b0;
    end
    glyph = ((idx_q != '0) && lead_zero) ? GLYPH_BLANK : nibble_to_glyph(cur_nib);

    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    if (enable) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = (SEG_ACTIVE_LOW != 0) ? ~glyph : glyph;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_duty_value_display.sv
// Scoreboard bench for duty_value_display: conversions are checked against decimal arithmetic
// and every display cycle against a scan model derived from elapsed clock edges.
module tb_duty_value_display;

  localparam int VALUE_W     = 17;
  localparam int DIGITS      = 6;
  localparam int REFRESH_DIV = 4;

  logic              clk    = 1'b0;
  logic              reset  = 1'b1;
  logic              enable = 1'b1;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;
  logic              dp;

  duty_value_display_if #(.VALUE_W(VALUE_W), .DIGITS(DIGITS)) conv ();

  duty_value_display #(
    .VALUE_W        (VALUE_W),
    .DIGITS         (DIGITS),
    .REFRESH_DIV    (REFRESH_DIV),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .conv   (conv),
    .enable (enable),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;
  int exp_q[$];
  int shown_val = 0;

  logic [6:0] glyph_al [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [23:0] bcd_of(input int val);
    logic [23:0] r;
    int v;
    r = '0;
    v = val;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_glyph(input int val, input int idx);
    int p;
    p = 1;
    for (int k = 0; k < idx; k++) p = p * 10;
    if (idx > 0 && val < p) return 7'h7F;
    return glyph_al[(val / p) % 10];
  endfunction

  // Display model: the digit shown after edge n is the one selected by edges before it.
  int         edges   = 0;
  logic [5:0] exp_an  = '1;
  logic [6:0] exp_seg = 7'h7F;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      edges   = 0;
      exp_an  = '1;
      exp_seg = 7'h7F;
    end else begin
      if (enable) begin
        exp_an  = ~(6'b1 << ((edges / REFRESH_DIV) % DIGITS));
        exp_seg = exp_glyph(shown_val, (edges / REFRESH_DIV) % DIGITS);
      end else begin
        exp_an  = '1;
        exp_seg = 7'h7F;
      end
      edges++;
    end
  end

  always @(negedge clk) begin
    check_output("an", 32'(an), 32'(exp_an));
    check_output("seg", 32'(seg), 32'(exp_seg));
    check_output("dp", 32'(dp), 32'd1);
  end

  // Monitor: every bcd_valid pulse must match the oldest accepted request.
  always @(negedge clk) begin
    if (reset && conv.bcd_valid) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_bcd_valid", 32'(conv.bcd), 32'hFFFF_FFFF);
      end else begin
        int v;
        v = exp_q.pop_front();
        check_output("bcd", 32'(conv.bcd), 32'(bcd_of(v)));
        shown_val = v;
      end
    end
  end

  task automatic apply_stimulus(input int val, input bit rogue, input int rogue_val);
    int busy_cycles;
    int lat;
    bit seen;
    busy_cycles = 0;
    lat         = 0;
    seen        = 1'b0;
    @(negedge clk);
    conv.value = VALUE_W'(val);
    conv.load  = 1'b1;
    exp_q.push_back(val);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      conv.load = 1'b0;
      if (rogue && n == 5) begin
        conv.load  = 1'b1;
        conv.value = VALUE_W'(rogue_val);
      end
      if (conv.bcd_valid) begin
        seen = 1'b1;
        lat  = n;
        break;
      end
      if (conv.busy) busy_cycles++;
    end
    check_output("valid_seen", 32'(seen), 32'd1);
    check_output("valid_latency", 32'(lat), 32'd19);
    check_output("busy_cycles", 32'(busy_cycles), 32'd18);
    @(negedge clk);
    check_output("valid_width", 32'(conv.bcd_valid), 32'd0);
    check_output("busy_after", 32'(conv.busy), 32'd0);
  endtask

  initial begin
    conv.value = '0;
    conv.load  = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    repeat (10) @(negedge clk);
    check_output("reset_bcd", 32'(conv.bcd), 32'd0);
    check_output("reset_busy", 32'(conv.busy), 32'd0);
    check_output("reset_valid", 32'(conv.bcd_valid), 32'd0);

    apply_stimulus(131071, 1'b0, 0);
    apply_stimulus(1205, 1'b0, 0);
    repeat (30) @(negedge clk);
    apply_stimulus(1205, 1'b1, 99);
    repeat (5) @(negedge clk);

    // Abort a conversion part way through.
    @(negedge clk);
    conv.value = VALUE_W'(98765);
    conv.load  = 1'b1;
    @(negedge clk);
    conv.load = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset     = 1'b0;
    shown_val = 0;
    #1;
    check_output("abort_busy", 32'(conv.busy), 32'd0);
    check_output("abort_bcd", 32'(conv.bcd), 32'd0);
    check_output("abort_an", 32'(an), 32'h3F);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    apply_stimulus(7, 1'b0, 0);

    @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    repeat (30) @(negedge clk);

    apply_stimulus(0, 1'b0, 0);
    for (int t = 0; t < 8; t++) begin
      apply_stimulus(int'($urandom_range(131071, 0)), 1'(t % 3 == 1), int'($urandom_range(131071, 0)));
      repeat (int'($urandom_range(12, 1))) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    check_output("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
